// File: rtl/reg_file_24_pkg.sv
// Shared widths, register/flag indices and flag packing for the 24-bit CPU datapath.
package reg_file_24_pkg;

    localparam int unsigned DATA_WIDTH = 24;
    localparam int unsigned ADDR_WIDTH = 3;
    localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;
    localparam int unsigned FLAG_WIDTH = 4;

    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = 3'd0;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [FLAG_WIDTH-1:0] flags_t;

    function automatic flags_t pack_flags(input logic z, input logic c, input logic n,
                                          input logic v);
        flags_t f;
        f         = '0;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/reg_file_24_status_reg.sv
// Load-enable status flag register with synchronous active-low reset.
module reg_file_24_status_reg
    import reg_file_24_pkg::*;
(
    input  logic   clock,
    input  logic   reset_n,
    input  logic   load,
    input  flags_t d,
    output flags_t q
);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file_24.sv
// 8 x 24-bit register file (R0 reads zero) with two async read ports, one sync write port,
// and the ALU status flag register.
module reg_file_24
    import reg_file_24_pkg::*;
(
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] RA1,
    input  logic [ADDR_WIDTH-1:0] RA2,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] WA,
    input  logic [DATA_WIDTH-1:0] WD,
    input  logic                  FlagWrite,
    input  logic                  ALUZero,
    input  logic                  ALUCarry,
    input  logic                  ALUNeg,
    input  logic                  ALUOvf,
    output logic [FLAG_WIDTH-1:0] Flags
);

    data_t rf [NUM_REGS];
    logic  write_en;

    assign write_en = RegWrite && (WA != REG_ZERO);
    assign rf[0]    = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_regs
        data_t q;

        always_ff @(posedge Clock) begin
            if (!Reset) begin
                q <= '0;
            end else if (write_en && (WA == ADDR_WIDTH'(i))) begin
                q <= WD;
            end
        end

        assign rf[i] = q;
    end

    // Reads see pre-edge contents only; a bypass would close RD->ALU->WD->RD.
    assign RD1 = rf[RA1];
    assign RD2 = rf[RA2];

    reg_file_24_status_reg u_status_reg (
        .clock   (Clock),
        .reset_n (Reset),
        .load    (FlagWrite),
        .d       (pack_flags(ALUZero, ALUCarry, ALUNeg, ALUOvf)),
        .q       (Flags)
    );

endmodule

// File: tb/tb_reg_file_24.sv
// Directed self-checking bench for reg_file_24 with hand-computed expected values.
module tb_reg_file_24;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [2:0]  RA1, RA2, WA;
    logic [23:0] RD1, RD2, WD;
    logic        RegWrite, FlagWrite;
    logic        ALUZero, ALUCarry, ALUNeg, ALUOvf;
    logic [3:0]  Flags;

    int n_vec = 0;
    int n_err = 0;

    reg_file_24 dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .RA1       (RA1),
        .RA2       (RA2),
        .RD1       (RD1),
        .RD2       (RD2),
        .RegWrite  (RegWrite),
        .WA        (WA),
        .WD        (WD),
        .FlagWrite (FlagWrite),
        .ALUZero   (ALUZero),
        .ALUCarry  (ALUCarry),
        .ALUNeg    (ALUNeg),
        .ALUOvf    (ALUOvf),
        .Flags     (Flags)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (Reset === 1'b1) begin
            assert (!$isunknown({RegWrite, FlagWrite}))
            else $error("protocol: X/Z on RegWrite/FlagWrite while out of reset");
        end
    end

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [23:0] d);
        WA       = a;
        WD       = d;
        RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0;
    endtask

    task automatic check_both(input string tag, input logic [2:0] a, input logic [23:0] exp);
        RA1 = a;
        RA2 = a;
        #1;
        check({tag, "_rd1"}, RD1, exp);
        check({tag, "_rd2"}, RD2, exp);
    endtask

    task automatic set_alu(input logic [3:0] vncz);
        {ALUOvf, ALUNeg, ALUCarry, ALUZero} = vncz;
    endtask

    logic [23:0] pat [8];

    initial begin
        Reset = 1'b0; RA1 = '0; RA2 = '0; WA = '0; WD = '0;
        RegWrite = 1'b0; FlagWrite = 1'b0; set_alu(4'b0000);

        // Power-on reset state
        tick();
        Reset = 1'b1;
        check("reset_flags", {20'h0, Flags}, 24'h0);
        check_both("reset_r7", 3'd7, 24'h0);

        // Fill with ones, then a single reset edge must clear everything
        for (int i = 1; i < 8; i++) write_reg(3'(i), 24'hFFFFFF);
        check_both("fill_r1", 3'd1, 24'hFFFFFF);
        check_both("fill_r7", 3'd7, 24'hFFFFFF);
        set_alu(4'b1111); FlagWrite = 1'b1; tick(); FlagWrite = 1'b0;
        check("fill_flags", {20'h0, Flags}, 24'h00000F);
        Reset = 1'b0; tick(); Reset = 1'b1;
        for (int i = 0; i < 8; i++) check_both("clr", 3'(i), 24'h0);
        check("clr_flags", {20'h0, Flags}, 24'h0);

        // Basic write/read with RA1 == RA2
        write_reg(3'd3, 24'h00ABCD);
        check_both("wr_r3", 3'd3, 24'h00ABCD);

        // Writes to R0 are discarded and don't leak elsewhere
        write_reg(3'd0, 24'h123456);
        check_both("r0", 3'd0, 24'h000000);
        check_both("r0_r3", 3'd3, 24'h00ABCD);

        // Distinct pattern per register exposes decode faults
        pat[0] = 24'h000000; pat[1] = 24'h111111; pat[2] = 24'h222222; pat[3] = 24'h333333;
        pat[4] = 24'h444444; pat[5] = 24'h555555; pat[6] = 24'h666666; pat[7] = 24'h777777;
        for (int i = 1; i < 8; i++) write_reg(3'(i), pat[i]);
        for (int i = 0; i < 8; i++) begin
            RA1 = 3'(i);
            RA2 = 3'(7 - i);
            #1;
            check("pat_rd1", RD1, pat[i]);
            check("pat_rd2", RD2, pat[7 - i]);
        end

        // RegWrite low: no write
        WA = 3'd4; WD = 24'hDEAD00; RegWrite = 1'b0; tick();
        check_both("nowrite_r4", 3'd4, 24'h444444);

        // No write-to-read bypass
        write_reg(3'd5, 24'h000010);
        RA1 = 3'd5; WA = 3'd5; WD = 24'h000020; RegWrite = 1'b1;
        #1;
        check("nobypass_before", RD1, 24'h000010);
        tick();
        RegWrite = 1'b0;
        check("nobypass_after", RD1, 24'h000020);

        // Flags load {V,N,C,Z} and hold
        set_alu(4'b1011); FlagWrite = 1'b1; tick();
        check("flags_1011", {20'h0, Flags}, 24'h00000B);
        set_alu(4'b0100); FlagWrite = 1'b0; tick();
        check("flags_hold", {20'h0, Flags}, 24'h00000B);
        FlagWrite = 1'b1; tick();
        check("flags_0100", {20'h0, Flags}, 24'h000004);
        set_alu(4'b0010); tick();
        check("flags_0010", {20'h0, Flags}, 24'h000002);

        // Register and flag writes in the same cycle
        set_alu(4'b1000); WA = 3'd6; WD = 24'hC0FFEE; RegWrite = 1'b1; tick();
        RegWrite = 1'b0; FlagWrite = 1'b0;
        check("both_flags", {20'h0, Flags}, 24'h000008);
        check_both("both_r6", 3'd6, 24'hC0FFEE);

        // Reset beats a pending register/flag write
        Reset = 1'b0; WA = 3'd2; WD = 24'h777777; RegWrite = 1'b1;
        set_alu(4'b1111); FlagWrite = 1'b1; tick();
        Reset = 1'b1; RegWrite = 1'b0; FlagWrite = 1'b0;
        check_both("rstprio_r2", 3'd2, 24'h0);
        check_both("rstprio_r6", 3'd6, 24'h0);
        check("rstprio_flags", {20'h0, Flags}, 24'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
